// File: rtl/multiplicador_shift_add_7bits.sv
// rtl/multiplicador_shift_add_7bits.sv - sequential unsigned shift-and-add multiplier, one multiplier bit per clock
// Optional feature macro: MULT_EARLY_EXIT_EN (finish as soon as the remaining multiplier bits are all zero)
module multiplicador_shift_add_7bits #(
  parameter int W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     multiplicando,
  input  logic [W-1:0]     multiplicador,
  output logic [2*W-1:0]   producto,
  output logic             busy,
  output logic             done
);

  localparam int            CW     = $clog2(W + 1);
  localparam logic [CW-1:0] C_LAST = CW'(W - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W:0]        r_a;
  logic [W-1:0]      r_q;
  logic [W-1:0]      r_m;
  logic [CW-1:0]     r_count;
  logic [2*W-1:0]    r_producto;
  logic              r_done;
  logic [W:0]        w_sum;

`ifdef MULT_EARLY_EXIT_EN
  // r_r tracks the multiplier bits not yet consumed; zero means nothing left to add
  logic [W-1:0]      r_r;
  logic              w_r_zero;
  logic [CW-1:0]     w_shamt;
  logic [2*W-1:0]    w_aligned;

  assign w_r_zero  = (r_r == '0);
  assign w_shamt   = CW'(W) - r_count;
  // A[W] is always zero after a shift, so the low 2W bits hold the whole partial product
  assign w_aligned = {r_a[W-1:0], r_q} >> w_shamt;
`endif

  // W+1 bit accumulator absorbs the carry, so the add cannot overflow
  assign w_sum    = r_q[0] ? (r_a + {1'b0, r_m}) : r_a;
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign producto = r_producto;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = STEP;
      STEP: begin
`ifdef MULT_EARLY_EXIT_EN
        if (w_r_zero)              w_next = FIN;
        else if (r_count == C_LAST) w_next = FIN;
`else
        if (r_count == C_LAST) w_next = FIN;
`endif
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // datapath: operand capture, shift-add iteration, result register and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_count    <= '0;
      r_producto <= '0;
      r_done     <= 1'b0;
`ifdef MULT_EARLY_EXIT_EN
      r_r        <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= multiplicador;
            r_m     <= multiplicando;
            r_count <= '0;
`ifdef MULT_EARLY_EXIT_EN
            r_r     <= multiplicador;
`endif
          end
        end
        STEP: begin
`ifdef MULT_EARLY_EXIT_EN
          if (!w_r_zero) begin
            {r_a, r_q} <= {w_sum, r_q} >> 1;
            r_count    <= r_count + C_ONE;
            r_r        <= r_r >> 1;
          end
`else
          {r_a, r_q} <= {w_sum, r_q} >> 1;
          r_count    <= r_count + C_ONE;
`endif
        end
        FIN: begin
`ifdef MULT_EARLY_EXIT_EN
          r_producto <= w_aligned;
`else
          r_producto <= {r_a[W-1:0], r_q};
`endif
          r_done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multiplicador_shift_add_7bits.md
Name: multiplicador_shift_add_7bits

Overview:
Sequential unsigned shift-and-add multiplier. It is the inverse-operation companion to the team's restoring divider and uses the same start/done handshake and one-bit-per-cycle iteration, so the two can share a datapath controller and testbench infrastructure. It computes multiplicando × multiplicador, one multiplier bit per clock, and delivers a registered 2W-bit product with a one-cycle done pulse.

Parameters:
W, 7, operand width in bits; product width is 2W.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
multiplicando  input  W  unsigned multiplicand; captured on accepted start
multiplicador  input  W  unsigned multiplier; captured on accepted start
producto  output  2W  registered product; holds the last result until the next FIN or reset
busy  output  1  high whenever state != IDLE; decoded from state
done  output  1  registered one-cycle pulse; producto is valid while done is high

Behaviour:
- Reset and clocking: one clock domain. Reset is synchronous, active-high. Reset values: state = IDLE; A, Q, M, R, count = 0; producto = 0; done = 0; busy = 0.
- Reset mid-operation: rst high at any edge aborts the operation. State returns to IDLE. No done pulse is produced and producto is cleared.
- States: IDLE, STEP, FIN. Encoding is 2 bits.
- IDLE:
  - On an edge with start = 1: A(W+1 bits) <= 0, Q <= multiplicador, M <= multiplicando, R <= multiplicador, count <= 0; go to STEP.
  - With start = 0: stay in IDLE.
- STEP (one iteration per cycle):
  - sum = A + {1'b0, M} if Q[0] = 1, else sum = A. Width is W+1, so no overflow is possible.
  - {A, Q} <= {sum, Q} >> 1, i.e. a logical right shift of the concatenation.
  - R <= R >> 1; count <= count + 1.
  - Go to FIN when count == W-1, at the edge performing the last step. Otherwise stay in STEP.
- FIN: producto <= {A[W-1:0], Q}; done <= 1; go to IDLE.
- done: cleared by default at every non-FIN edge, so it is high for exactly one cycle.
- Latency (macro off): start sampled at edge 0; steps run at edges 1..W; the FIN action occurs at edge W+1. done and producto are therefore visible in the cycle after edge W+1. For W = 7, done is high between edges 8 and 9.
- Back-to-back operation: the cycle in which done is high is an IDLE cycle. A start asserted in that cycle is accepted at the next edge. Maximum throughput is one result every W+2 cycles.
- start while busy: ignored entirely. Operand changes while busy have no effect, because operands are captured only at acceptance.
- Boundary conditions:
  - Either operand 0 gives product 0.
  - Maximum for W = 7: 127 × 127 = 16129 (0x3F01).
  - A never exceeds 2^W - 1 after the shift.

Optional Feature:
MULT_EARLY_EXIT_EN
- Defined:
  - In STEP, if R == 0 on entry, no step is performed and the block goes to FIN. Remaining multiplier bits are all zero, so they contribute nothing.
  - FIN then loads producto <= ({A, Q} >> (W - count))[2W-1:0] through a barrel shifter, restoring alignment.
  - Let n = bit position of the multiplier MSB + 1 (n = 0 for multiplier 0). Done appears after edge min(n, W) + 2 when n < W, and after edge W+1 when n = W.
  - Results are identical to the macro-off build.
- Undefined: fixed latency of W+2 cycles start-to-done as specified above. R and the barrel shifter are not synthesized.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles with start = 1 -> producto = 0, done = 0, busy = 0. Release rst with start = 0 -> state remains IDLE.
- Basic product: 13 × 11 with start pulsed at edge 0 -> busy high from edge 1, done high one cycle after edge 8, producto = 143 (0x008F).
- Extremes:
  - 127 × 127 -> 0x3F01.
  - 0 × 99 -> 0.
  - 99 × 0 -> 0.
  - 1 × 127 -> 127.
  - Macro off: all four take exactly 9 edges.
- Ignored start and operand change: start held high and operands changed during STEP -> result is the originally captured 25 × 5 = 125. Exactly one done pulse.
- Back-to-back: start asserted during the done cycle with 3 × 7 -> accepted. Second done pulse 9 cycles later with producto = 21.
- Mid-operation reset and early exit:
  - rst pulsed at edge 4 of a 100 × 100 operation -> IDLE, producto = 0, no done pulse.
  - With MULT_EARLY_EXIT_EN: 100 × 0 -> done after edge 2; 100 × 3 -> done after edge 4, producto = 300.
